// File: rtl/subtree_rr_scheduler.sv
// Round-robin scheduler sharing one resource among the child instances of a
// subtree node, with a hold-time watchdog that preempts stuck owners.
module subtree_rr_scheduler #(
   parameter int NUM_REQ  = 5,
   parameter int MAX_HOLD = 16,
   parameter int ID_W     = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] done,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic               busy,
   output logic               timeout
);

   localparam int CNT_W = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]    last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               timeout_q, timeout_d;

   logic               sel_found;
   logic [ID_W-1:0]    sel_id;
   logic               rel_done;
   logic               rel_drop;
   logic               expire;

   // Pick the first requester strictly after the last released child.
   always_comb begin
      int idx;
      logic [ID_W-1:0] idx_w;
      sel_found = 1'b0;
      sel_id    = '0;
      idx       = 0;
      idx_w     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(last_q) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         idx_w = ID_W'(idx);
         if (!sel_found && req[idx_w]) begin
            sel_found = 1'b1;
            sel_id    = idx_w;
         end
      end
   end

   // Release conditions looked at only on the current owner's bits.
   always_comb begin
      rel_done = done[gnt_id_q];
      rel_drop = !req[gnt_id_q];
      expire   = (cnt_q == HOLD_LAST);
   end

   // Next-state and registered-output logic for IDLE/GRANT/GAP.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sel_found) begin
               state_d  = GRANT;
               gnt_d    = NUM_REQ'(1) << sel_id;
               gnt_id_d = sel_id;
               cnt_d    = '0;
            end
         end
         GRANT: begin
            if (rel_done || rel_drop || expire) begin
               state_d   = GAP;
               gnt_d     = '0;
               gnt_id_d  = '0;
               last_d    = gnt_id_q;
               cnt_d     = '0;
               timeout_d = !(rel_done || rel_drop);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            cnt_d    = '0;
         end
      endcase
   end

   // State and output registers; reset clears grant without a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         last_q    <= LAST_RST;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = |gnt_q;
   assign gnt_id    = gnt_id_q;
   assign busy      = (state_q != IDLE);
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_subtree_rr_scheduler.sv
// Bench for subtree_rr_scheduler: directed scenarios plus random traffic
// compared every cycle against an owner/hold-count reference model.
module tb_subtree_rr_scheduler;

   localparam int N  = 5;
   localparam int MH = 16;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  done = '0;
   logic [N-1:0]  gnt;
   logic          gnt_valid;
   logic [IW-1:0] gnt_id;
   logic          busy;
   logic          timeout;

   int checks = 0;
   int errors = 0;

   subtree_rr_scheduler #(
      .NUM_REQ (N),
      .MAX_HOLD(MH),
      .ID_W    (IW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .done     (done),
      .gnt      (gnt),
      .gnt_valid(gnt_valid),
      .gnt_id   (gnt_id),
      .busy     (busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   // reference model: who owns the resource, for how long, and whose turn next
   int m_owner = -1;
   int m_held  = 0;
   int m_last  = N - 1;
   bit m_gap   = 1'b0;
   bit m_to    = 1'b0;

   function automatic bit bit_of(input logic [N-1:0] v, input int i);
      logic [IW-1:0] ix;
      ix = IW'(i);
      return v[ix];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1;
         m_held  = 0;
         m_last  = N - 1;
         m_gap   = 1'b0;
         m_to    = 1'b0;
      end else begin
         m_to = 1'b0;
         if (m_owner >= 0) begin
            m_held = m_held + 1;
            if (bit_of(done, m_owner) || !bit_of(req, m_owner) || m_held == MH) begin
               m_to    = !bit_of(done, m_owner) && bit_of(req, m_owner);
               m_last  = m_owner;
               m_owner = -1;
               m_gap   = 1'b1;
            end
         end else if (m_gap) begin
            m_gap = 1'b0;
         end else begin
            for (int k = 1; k <= N; k++) begin
               if (m_owner < 0 && bit_of(req, (m_last + k) % N)) begin
                  m_owner = (m_last + k) % N;
                  m_held  = 0;
               end
            end
         end
      end
   end

   function automatic logic [N-1:0] exp_gnt();
      logic [N-1:0] one;
      one = N'(1);
      return (m_owner >= 0) ? (one << m_owner) : '0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         chk("gnt", 32'(gnt), 32'(exp_gnt()));
         chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
         chk("gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
         chk("busy", 32'(busy), 32'((m_owner >= 0) || m_gap));
         chk("timeout", 32'(timeout), 32'(m_to));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      req   = '0;
      done  = '0;
      tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_id", 32'(gnt_id), 32'd0);
      chk("rst_to", 32'(timeout), 32'd0);
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_gnt(input int lim, output int n);
      n = 0;
      while (!gnt_valid && n < lim) begin
         tick();
         n++;
      end
      if (!gnt_valid) chk("wait_gnt", 32'(gnt_valid), 32'd1);
   endtask

   initial begin
      int n;
      int h;

      // single requester with done release
      reset_dut();
      req = 5'b00001;
      tick();
      chk("t1_gnt", 32'(gnt), 32'h01);
      chk("t1_model", 32'(exp_gnt()), 32'h01);
      tick();
      tick();
      done = 5'b00001;
      tick();
      done = '0;
      chk("t1_drop", 32'(gnt), 32'd0);
      chk("t1_gap_busy", 32'(busy), 32'd1);
      chk("t1_to", 32'(timeout), 32'd0);
      tick();
      chk("t1_idle_busy", 32'(busy), 32'd0);
      tick();
      chk("t1_regnt", 32'(gnt), 32'h01);
      req = '0;
      repeat (3) tick();

      // all requesting: round-robin order and 2-cycle spacing
      reset_dut();
      req = '1;
      for (int i = 0; i < 6; i++) begin
         wait_gnt(10, n);
         if (i == 0) chk("rr_lat", 32'(n), 32'd1);
         else chk("rr_space", 32'(n), 32'd2);
         chk("rr_id", 32'(gnt_id), 32'(i % N));
         tick();
         done = gnt;
         tick();
         done = '0;
         chk("rr_drop", 32'(gnt), 32'd0);
      end
      req = '0;
      repeat (3) tick();

      // hold-time preemption
      reset_dut();
      req = 5'b00100;
      wait_gnt(5, n);
      h = 0;
      while (gnt_valid && h < 40) begin
         tick();
         h++;
      end
      chk("t3_hold", 32'(h), 32'd16);
      chk("t3_to", 32'(timeout), 32'd1);
      chk("t3_model_to", 32'(m_to), 32'd1);
      tick();
      chk("t3_to_pulse", 32'(timeout), 32'd0);
      tick();
      tick();
      chk("t3_regnt", 32'(gnt), 32'h04);
      req = '0;
      repeat (3) tick();

      // done coincident with expiry
      reset_dut();
      req = 5'b01000;
      wait_gnt(5, n);
      chk("t4_id", 32'(gnt_id), 32'd3);
      req = 5'b01011;
      repeat (15) tick();
      done = 5'b01000;
      tick();
      done = '0;
      chk("t4_drop", 32'(gnt), 32'd0);
      chk("t4_to", 32'(timeout), 32'd0);
      tick();
      tick();
      chk("t4_next", 32'(gnt), 32'h01);
      req = '0;
      repeat (3) tick();

      // foreign done ignored, release on req drop
      reset_dut();
      req = 5'b00010;
      wait_gnt(5, n);
      chk("t5_id", 32'(gnt_id), 32'd1);
      req = 5'b10010;
      tick();
      done = 5'b10000;
      tick();
      done = '0;
      chk("t5_hold", 32'(gnt), 32'h02);
      req = 5'b10000;
      tick();
      chk("t5_drop", 32'(gnt), 32'd0);
      chk("t5_to", 32'(timeout), 32'd0);
      tick();
      tick();
      chk("t5_next", 32'(gnt), 32'h10);
      req = '0;
      repeat (3) tick();

      // asynchronous reset mid-grant
      reset_dut();
      req = 5'b00001;
      wait_gnt(5, n);
      tick();
      #3;
      rst_n = 1'b0;
      #2;
      chk("t6_gnt", 32'(gnt), 32'd0);
      chk("t6_valid", 32'(gnt_valid), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_id", 32'(gnt_id), 32'd0);
      req = 5'b01000;
      #2;
      rst_n = 1'b1;
      tick();
      chk("t6_first", 32'(gnt), 32'h08);
      req = 5'b01001;
      tick();
      done = 5'b01000;
      tick();
      done = '0;
      tick();
      tick();
      chk("t6_wrap", 32'(gnt_id), 32'd0);
      req = '0;
      repeat (3) tick();

      // random traffic against the model
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 9) == 0) req = N'($urandom);
         if (c < 2000) done = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
         else done = ($urandom_range(0, 40) == 0) ? N'($urandom) : '0;
         if (c == 1500 || c == 3000) begin
            #3;
            rst_n = 1'b0;
            #3;
            rst_n = 1'b1;
         end
         tick();
      end

      req  = '0;
      done = '0;
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
